// File: rtl/gpu_pkg.sv
// Shared types and constants for the vertex feeder slice:
// lane geometry, vector type, identity rows and FSM states.
package gpu_pkg;

    localparam int W     = 10;
    localparam int LANES = 4;

    typedef logic [LANES*W-1:0] vec_t;

    // Lane 0 lives in the MSB field, so row r has its 1 in lane r.
    localparam vec_t IDENTITY_ROW [LANES] = '{
        vec_t'(1) << (3*W),
        vec_t'(1) << (2*W),
        vec_t'(1) << W,
        vec_t'(1)
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OUT
    } fsm_t;

endpackage

// File: rtl/vertex_fifo.sv
// Vertex FIFO: DEPTH entries of vec_t, synchronous active-high reset.
// Ports: push/wdata write, pop/rdata read (rdata = head), full/empty/count status.
module vertex_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  vec_t        wdata,
    input  logic        pop,
    output vec_t        rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    vec_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer bit tells a full FIFO apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmul_vertex_feeder.sv
// Sequencer in front of the combinational 4x4 matrix-vector multiplier.
// Ports: mat_we/mat_row/mat_data load shadow rows, mat_swap copies shadow->active;
// vin_* accepts vertices; A0..A3/P drive the multiplier, C is its result;
// vout_* delivers results; busy and vtx_count report activity.
module mmul_vertex_feeder
    import gpu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mat_we,
    input  logic [1:0]     mat_row,
    input  logic [4*W-1:0] mat_data,
    input  logic           mat_swap,
    input  logic           vin_valid,
    output logic           vin_ready,
    input  logic [4*W-1:0] vin_data,
    output logic [4*W-1:0] A0,
    output logic [4*W-1:0] A1,
    output logic [4*W-1:0] A2,
    output logic [4*W-1:0] A3,
    output logic [4*W-1:0] P,
    input  logic [4*W-1:0] C,
    output logic           vout_valid,
    input  logic           vout_ready,
    output logic [4*W-1:0] vout_data,
    output logic           busy,
    output logic [15:0]    vtx_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    fsm_t             state;
    fsm_t             state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    vec_t             active [LANES];
    vec_t             shadow [LANES];
    logic             swap_pending;
    logic             pop;
    logic             apply;
    logic             capture;
    logic             deliver;
    logic             push;
    vec_t             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;

    assign vin_ready = !rst && !fifo_full && !swap_pending;
    assign push      = vin_valid && vin_ready;

    vertex_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (vin_data),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign A0   = active[0];
    assign A1   = active[1];
    assign A2   = active[2];
    assign A3   = active[3];
    assign busy = (fifo_count != '0) || (state != IDLE) || swap_pending;

    // A waiting swap blocks new pushes, so everything already queued
    // still drains under the old matrix before the swap lands.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        apply   = 1'b0;
        capture = 1'b0;
        deliver = 1'b0;
        unique case (state)
            IDLE: begin
                if (swap_pending && fifo_empty) begin
                    apply = 1'b1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    cnt_n   = CNT_W'(SETTLE_CYC - 1);
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = OUT;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            OUT: begin
                if (vout_ready) begin
                    deliver = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active       <= IDENTITY_ROW;
            shadow       <= IDENTITY_ROW;
            swap_pending <= 1'b0;
            P            <= '0;
            vout_valid   <= 1'b0;
            vout_data    <= '0;
            vtx_count    <= '0;
        end else begin
            if (mat_we) begin
                shadow[mat_row] <= mat_data;
            end
            if (apply) begin
                active       <= shadow;
                swap_pending <= 1'b0;
            end else if (mat_swap) begin
                swap_pending <= 1'b1;
            end
            if (pop) begin
                P <= fifo_head;
            end
            if (capture) begin
                vout_data  <= C;
                vout_valid <= 1'b1;
            end
            if (deliver) begin
                vout_valid <= 1'b0;
                vtx_count  <= vtx_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmul_vertex_feeder.sv
// Self-checking bench for mmul_vertex_feeder with a behavioural
// multiplier beside it and a queue-based reference model.
module tb_mmul_vertex_feeder;
    import gpu_pkg::*;

    localparam int DEPTH      = 4;
    localparam int SETTLE_CYC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mat_we;
    logic [1:0]  mat_row;
    vec_t        mat_data;
    logic        mat_swap;
    logic        vin_valid;
    logic        vin_ready;
    vec_t        vin_data;
    vec_t        A0, A1, A2, A3, P, C;
    logic        vout_valid;
    logic        vout_ready;
    vec_t        vout_data;
    logic        busy;
    logic [15:0] vtx_count;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_act [4][4];
    logic [W-1:0] m_shd [4][4];
    vec_t         exp_q [$];
    vec_t         out_q [$];
    logic [15:0]  m_count;
    int           accept_outs;

    always #5 clk = ~clk;

    mmul_vertex_feeder #(
        .DEPTH      (DEPTH),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mat_we     (mat_we),
        .mat_row    (mat_row),
        .mat_data   (mat_data),
        .mat_swap   (mat_swap),
        .vin_valid  (vin_valid),
        .vin_ready  (vin_ready),
        .vin_data   (vin_data),
        .A0         (A0),
        .A1         (A1),
        .A2         (A2),
        .A3         (A3),
        .P          (P),
        .C          (C),
        .vout_valid (vout_valid),
        .vout_ready (vout_ready),
        .vout_data  (vout_data),
        .busy       (busy),
        .vtx_count  (vtx_count)
    );

    function automatic logic [W-1:0] lane(vec_t v, int j);
        return v[(LANES-1-j)*W +: W];
    endfunction

    function automatic vec_t pack4(int a, int b, int c, int d);
        return {W'(a), W'(b), W'(c), W'(d)};
    endfunction

    function automatic vec_t rand_vec();
        return {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
    endfunction

    // Stand-in for the neighbouring combinational multiplier.
    function automatic vec_t mmulp(vec_t a0, vec_t a1, vec_t a2,
                                   vec_t a3, vec_t p);
        vec_t rows [4];
        vec_t r;
        logic [W-1:0] acc;
        rows = '{a0, a1, a2, a3};
        r = '0;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                acc = acc + W'(lane(rows[i], j) * lane(p, j));
            end
            r[(LANES-1-i)*W +: W] = acc;
        end
        return r;
    endfunction

    assign C = mmulp(A0, A1, A2, A3, P);

    // Reference: result = active matrix times vertex, each lane mod 2^W.
    function automatic vec_t ref_mul(vec_t v);
        vec_t r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = 0;
            for (int j = 0; j < 4; j++) begin
                s += int'(m_act[i][j]) * int'(lane(v, j));
            end
            s = s % (1 << W);
            r[(LANES-1-i)*W +: W] = W'(s);
        end
        return r;
    endfunction

    function automatic vec_t model_row(int i);
        return {m_act[i][0], m_act[i][1], m_act[i][2], m_act[i][3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                m_act[i][j] = (i == j) ? W'(1) : W'(0);
                m_shd[i][j] = (i == j) ? W'(1) : W'(0);
            end
        end
        exp_q.delete();
        m_count = 16'd0;
    endtask

    task automatic write_row(int r, vec_t v);
        mat_we   = 1'b1;
        mat_row  = 2'(r);
        mat_data = v;
        tick();
        mat_we = 1'b0;
        for (int j = 0; j < 4; j++) m_shd[r][j] = lane(v, j);
    endtask

    // Pushes are held off while a swap waits, so the model can switch now.
    task automatic swap();
        mat_swap = 1'b1;
        tick();
        mat_swap = 1'b0;
        m_act = m_shd;
    endtask

    task automatic push(vec_t v);
        int n;
        vin_valid = 1'b1;
        vin_data  = v;
        n = 0;
        while (!vin_ready && n < 300) begin
            tick();
            n++;
        end
        if (!vin_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: vin_ready=%0b required 1", vin_ready);
            vin_valid = 1'b0;
            return;
        end
        accept_outs = out_q.size();
        exp_q.push_back(ref_mul(v));
        tick();
        vin_valid = 1'b0;
    endtask

    task automatic collect(int n, bit rnd);
        out_q.delete();
        for (int c = 0; c < 3000 && out_q.size() < n; c++) begin
            vout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vout_valid && vout_ready) begin
                out_q.push_back(vout_data);
                m_count++;
            end
            tick();
        end
        vout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mat_we = 1'b0; mat_row = '0; mat_data = '0; mat_swap = 1'b0;
        vin_valid = 1'b0; vin_data = '0; vout_ready = 1'b0;
        model_reset();
        #1;
        total++;
        if (vin_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_vin_ready: got %0b want 0", vin_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            vec_t a;
            a = (i == 0) ? A0 : (i == 1) ? A1 : (i == 2) ? A2 : A3;
            total++;
            if (a !== model_row(i)) begin
                bad++;
                $display("FAIL rst_A%0d: got %h want %h", i, a, model_row(i));
            end
        end
        total++;
        if (P !== '0 || vout_valid !== 1'b0 || vout_data !== '0) begin
            bad++;
            $display("FAIL rst_outputs: P=%h valid=%0b data=%h want 0",
                     P, vout_valid, vout_data);
        end
        total++;
        if (vtx_count !== 16'd0 || busy !== 1'b0 || vin_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_status: count=%0d busy=%0b ready=%0b want 0 0 1",
                     vtx_count, busy, vin_ready);
        end
    endtask

    task automatic test_identity();
        vec_t v;
        logic [2:0] seen;
        v = pack4(5, 6, 5, 3);
        vout_ready = 1'b1;
        vin_valid  = 1'b1;
        vin_data   = v;
        exp_q.push_back(ref_mul(v));
        tick();
        vin_valid = 1'b0;
        seen[0] = vout_valid;
        tick();
        seen[1] = vout_valid;
        tick();
        seen[2] = vout_valid;
        total++;
        if (seen !== 3'b100) begin
            bad++;
            $display("FAIL latency: valid after edges k..k+2=%b want 100", seen);
        end
        total++;
        if (vout_data !== pack4(5, 6, 5, 3) || vout_data !== exp_q[0]) begin
            bad++;
            $display("FAIL identity_data: got %h want %h", vout_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        m_count++;
        tick();
        vout_ready = 1'b0;
        total++;
        if (vout_valid !== 1'b0 || vtx_count !== m_count || busy !== 1'b0) begin
            bad++;
            $display("FAIL identity_after: valid=%0b count=%0d busy=%0b want 0 %0d 0",
                     vout_valid, vtx_count, busy, m_count);
        end
    endtask

    task automatic test_matrix();
        write_row(0, pack4(5, 6, 5, 3));
        write_row(1, pack4(18, 4, 10, 0));
        write_row(2, pack4(6, 18, 7, 12));
        write_row(3, pack4(1, 14, 4, 2));
        total++;
        if (A1 !== pack4(0, 1, 0, 0)) begin
            bad++;
            $display("FAIL shadow_isolated: A1=%h want %h", A1, pack4(0, 1, 0, 0));
        end
        swap();
        tick();
        total++;
        if (A2 !== pack4(6, 18, 7, 12) || A3 !== model_row(3)) begin
            bad++;
            $display("FAIL swap_applied: A2=%h A3=%h", A2, A3);
        end
        push(pack4(1, 1, 1, 1));
        collect(1, 1'b0);
        total++;
        if (out_q.size() != 1 || out_q[0] !== pack4(19, 32, 43, 21)) begin
            bad++;
            $display("FAIL matrix_data: got %h want %h",
                     (out_q.size() > 0) ? out_q[0] : 'x, pack4(19, 32, 43, 21));
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_backpressure();
        vec_t held;
        vout_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(rand_vec());
        total++;
        if (vin_ready !== 1'b0 || busy !== 1'b1 || vout_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full: ready=%0b busy=%0b valid=%0b want 0 1 1",
                     vin_ready, busy, vout_valid);
        end
        held = exp_q[0];
        vin_valid = 1'b1;
        vin_data  = rand_vec();
        for (int c = 0; c < 4; c++) begin
            total++;
            if (vin_ready !== 1'b0 || vout_data !== held || vout_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold: ready=%0b data=%h want 0 %h",
                         vin_ready, vout_data, held);
            end
            tick();
        end
        vin_valid = 1'b0;
        collect(DEPTH + 1, 1'b0);
        total++;
        if (out_q.size() != DEPTH + 1) begin
            bad++;
            $display("FAIL bp_count: got %0d want %0d", out_q.size(), DEPTH + 1);
        end
        for (int i = 0; i < out_q.size(); i++) begin
            vec_t e;
            e = exp_q.pop_front();
            total++;
            if (out_q[i] !== e) begin
                bad++;
                $display("FAIL bp_order%0d: got %h want %h", i, out_q[i], e);
            end
        end
    endtask

    task automatic test_swap_order();
        vec_t v3;
        vec_t twice;
        vout_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            write_row(r, vec_t'(2) << ((3 - r) * W));
        end
        push(rand_vec());
        push(rand_vec());
        swap();
        total++;
        if (vin_ready !== 1'b0 || busy !== 1'b1 || A0 !== model_row(0) && 1'b0) begin
            bad++;
            $display("FAIL swap_block: ready=%0b busy=%0b want 0 1", vin_ready, busy);
        end
        v3 = rand_vec();
        twice = '0;
        for (int j = 0; j < 4; j++) begin
            twice[(LANES-1-j)*W +: W] = W'((2 * int'(lane(v3, j))) % (1 << W));
        end
        out_q.delete();
        accept_outs = -1;
        fork
            collect(3, 1'b0);
            push(v3);
        join
        total++;
        if (accept_outs != 2) begin
            bad++;
            $display("FAIL swap_accept: outputs before accept=%0d want 2", accept_outs);
        end
        total++;
        if (out_q.size() != 3) begin
            bad++;
            $display("FAIL swap_count: got %0d want 3", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            vec_t e;
            e = exp_q.pop_front();
            total++;
            if (out_q[i] !== e || (i == 2 && out_q[i] !== twice)) begin
                bad++;
                $display("FAIL swap_data%0d: got %h want %h", i, out_q[i], e);
            end
        end
    endtask

    task automatic test_random();
        int n;
        n = 30;
        for (int r = 0; r < 4; r++) write_row(r, rand_vec());
        swap();
        tick();
        out_q.delete();
        fork
            collect(n, 1'b1);
            begin
                for (int i = 0; i < n; i++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) tick();
                    push(rand_vec());
                end
            end
        join
        total++;
        if (out_q.size() != n) begin
            bad++;
            $display("FAIL rand_count: got %0d want %0d", out_q.size(), n);
        end
        for (int i = 0; i < out_q.size(); i++) begin
            vec_t e;
            e = exp_q.pop_front();
            total++;
            if (out_q[i] !== e) begin
                bad++;
                $display("FAIL rand_data%0d: got %h want %h", i, out_q[i], e);
            end
        end
        total++;
        if (vtx_count !== m_count) begin
            bad++;
            $display("FAIL rand_vtx_count: got %0d want %0d", vtx_count, m_count);
        end
    endtask

    task automatic test_wrap();
        force dut.vtx_count = 16'hFFFF;
        tick();
        release dut.vtx_count;
        m_count = 16'hFFFF;
        tick();
        push(rand_vec());
        collect(1, 1'b0);
        total++;
        if (out_q.size() != 1 || vtx_count !== m_count || vtx_count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap: count=%h want 0000", vtx_count);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid();
        vec_t vs [5];
        vout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vs[i] = rand_vec();
            push(vs[i]);
        end
        vout_ready = 1'b1;
        total++;
        if (vout_valid !== 1'b1 || vout_data !== exp_q[0]) begin
            bad++;
            $display("FAIL mid_first: data=%h want %h", vout_data, exp_q[0]);
        end
        tick();
        vout_ready = 1'b0;
        tick();
        total++;
        if (P !== vs[1] || vout_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_settle: P=%h want %h valid=%0b", P, vs[1], vout_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (vout_valid !== 1'b0 || busy !== 1'b0 || vtx_count !== 16'd0 || P !== '0) begin
            bad++;
            $display("FAIL mid_rst: valid=%0b busy=%0b count=%0d P=%h want 0",
                     vout_valid, busy, vtx_count, P);
        end
        total++;
        if (A0 !== model_row(0) || A1 !== model_row(1) ||
            A2 !== model_row(2) || A3 !== model_row(3)) begin
            bad++;
            $display("FAIL mid_rst_A: A0=%h A3=%h want identity", A0, A3);
        end
        vout_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            total++;
            if (vout_valid !== 1'b0 || vin_ready !== 1'b1) begin
                bad++;
                $display("FAIL mid_discard: valid=%0b ready=%0b want 0 1",
                         vout_valid, vin_ready);
            end
            tick();
        end
        vout_ready = 1'b0;
        swap();
        tick();
        total++;
        if (A1 !== model_row(1) || A1 !== pack4(0, 1, 0, 0)) begin
            bad++;
            $display("FAIL mid_shadow: A1=%h want identity row", A1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_matrix();
        test_backpressure();
        test_swap_order();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
